// File: rtl/dda_step_sequencer.sv
// Sequencer for a damped spring-mass forward-Euler solver. It owns the v1/v2 state
// and coefficients, and time-shares one external 7.20 multiplier across three cycles per step.
module dda_step_sequencer #(
  parameter int WIDTH    = 27,
  parameter int FRAC     = 20,
  parameter int DT_SHIFT = 9,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             load,
  input  logic             start,
  input  logic [CNT_W-1:0] n_steps,
  input  logic             halt,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_p,
  output logic [WIDTH-1:0] v1,
  output logic [WIDTH-1:0] v2,
  output logic             busy,
  output logic             step_done,
  output logic             done,
  output logic [CNT_W-1:0] step_cnt
);

  localparam logic [WIDTH-1:0] K_M_RST = WIDTH'(1) << (FRAC - 1);   // 0.5
  localparam logic [WIDTH-1:0] D_M_RST = WIDTH'(1) << (FRAC - 2);   // 0.25
  localparam logic [WIDTH-1:0] IC2_RST = WIDTH'(10) << FRAC;        // 10.0

  typedef enum logic [1:0] {IDLE, MUL_K, MUL_D, UPDATE} state_t;

  state_t                   state;
  logic [WIDTH-1:0]         k_m, d_m, ic1, ic2;
  logic signed [WIDTH-1:0]  p_k, p_d;
  logic [CNT_W-1:0]         steps_left;

  // Kept as separate signed nets so the shifts stay arithmetic; inside a mixed
  // unsigned expression the >>> would silently become a logical shift.
  logic signed [WIDTH-1:0]  v2_dt, acc_sum, acc_dt;
  assign v2_dt   = $signed(v2) >>> DT_SHIFT;
  assign acc_sum = -p_k - p_d;
  assign acc_dt  = acc_sum >>> DT_SHIFT;

  // The multiplier answers in the same cycle, so the operands are steered
  // combinationally from the current state.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    mul_a = '0;
    mul_b = '0;
    case (state)
      MUL_K: begin mul_a = v1; mul_b = k_m; end
      MUL_D: begin mul_a = v2; mul_b = d_m; end
      default: ;
    endcase
  end

  // NOTE: all state below updates with <= so every register samples pre-edge values,
  // which is what makes UPDATE use the old v1/v2 for both equations.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k_m        <= K_M_RST;
      d_m        <= D_M_RST;
      ic1        <= '0;
      ic2        <= IC2_RST;
      v1         <= '0;
      v2         <= IC2_RST;
      p_k        <= '0;
      p_d        <= '0;
      steps_left <= '0;
      step_cnt   <= '0;
      busy       <= 1'b0;
      step_done  <= 1'b0;
      done       <= 1'b0;
    end else begin
      step_done <= 1'b0;
      done      <= 1'b0;
      if (halt && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_we) begin
              case (cfg_addr)
                2'd0: k_m <= cfg_data;
                2'd1: d_m <= cfg_data;
                2'd2: ic1 <= cfg_data;
                2'd3: ic2 <= cfg_data;
              endcase
            end
            if (load) begin
              v1       <= ic1;
              v2       <= ic2;
              step_cnt <= '0;
            end else if (start && n_steps != '0) begin
              steps_left <= n_steps;
              state      <= MUL_K;
              busy       <= 1'b1;
            end
          end
          MUL_K: begin
            p_k   <= $signed(mul_p);
            state <= MUL_D;
          end
          MUL_D: begin
            p_d   <= $signed(mul_p);
            state <= UPDATE;
          end
          UPDATE: begin
            v1         <= v1 + v2_dt;
            v2         <= v2 + acc_dt;
            step_done  <= 1'b1;
            step_cnt   <= step_cnt + 1'b1;
            steps_left <= steps_left - 1'b1;
            if (steps_left == CNT_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= MUL_K;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dda_step_sequencer.sv
// Bench for dda_step_sequencer: a 7.20 multiplier model drives mul_p, and an arithmetic
// Euler model predicts the bus and state cycle by cycle, plus table vectors and corner cases.
module tb_dda_step_sequencer;
  localparam int W = 27;

  logic          clk = 1'b0;
  logic          rst, cfg_we, load, start, halt;
  logic [1:0]    cfg_addr;
  logic [W-1:0]  cfg_data;
  logic [15:0]   n_steps;
  logic [W-1:0]  mul_a, mul_b, mul_p, v1, v2;
  logic          busy, step_done, done;
  logic [15:0]   step_cnt;
  logic [W-1:0]  mul_a4, mul_b4, mul_p4, v1_4, v2_4;
  logic          busy4, step_done4, done4;
  logic [3:0]    step_cnt4;

  int     n_checks = 0;
  int     n_errors = 0;
  bit     noise = 1'b0;
  longint m_k, m_d, m_ic1, m_ic2, m_v1, m_v2;
  int     m_cnt;

  always #5 clk = ~clk;

  function automatic longint sx(input logic [W-1:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint wrap(input longint x);
    logic [W-1:0] t;
    t = x[W-1:0];
    return sx(t);
  endfunction

  // 7.20 multiply: exact product, floor to 20 fractional bits, keep the low 27 bits.
  function automatic longint mmul(input longint a, input longint b);
    return wrap((a * b) >>> 20);
  endfunction

  assign mul_p  = W'(mmul(sx(mul_a), sx(mul_b)));
  assign mul_p4 = W'(mmul(sx(mul_a4), sx(mul_b4)));

  dda_step_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .load(load), .start(start), .n_steps(n_steps), .halt(halt),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .v1(v1), .v2(v2),
    .busy(busy), .step_done(step_done), .done(done), .step_cnt(step_cnt)
  );

  dda_step_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .load(load), .start(start), .n_steps(n_steps[3:0]), .halt(halt),
    .mul_a(mul_a4), .mul_b(mul_b4), .mul_p(mul_p4), .v1(v1_4), .v2(v2_4),
    .busy(busy4), .step_done(step_done4), .done(done4), .step_cnt(step_cnt4)
  );

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_k = 'h0080000; m_d = 'h0040000; m_ic1 = 0; m_ic2 = 'h0A00000;
    m_v1 = 0; m_v2 = 'h0A00000; m_cnt = 0;
  endtask

  task automatic model_step();
    longint pk, pd, nv1, nv2;
    pk  = mmul(m_v1, m_k);
    pd  = mmul(m_v2, m_d);
    nv1 = wrap(m_v1 + (m_v2 >>> 9));
    nv2 = wrap(m_v2 + (wrap(-pk - pd) >>> 9));
    m_v1 = nv1; m_v2 = nv2;
    m_cnt = (m_cnt + 1) & 'hFFFF;
  endtask

  task automatic check_reset_state();
    check("rst_v1", $signed(v1), 0);
    check("rst_v2", $signed(v2), 'h0A00000);
    check("rst_busy", busy, 0);
    check("rst_step_done", step_done, 0);
    check("rst_done", done, 0);
    check("rst_step_cnt", step_cnt, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
  endtask

  task automatic do_cfg(input logic [1:0] addr, input logic [W-1:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    tick();
    cfg_we = 1'b0;
    case (addr)
      2'd0: m_k   = sx(data);
      2'd1: m_d   = sx(data);
      2'd2: m_ic1 = sx(data);
      2'd3: m_ic2 = sx(data);
    endcase
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
    m_v1 = m_ic1; m_v2 = m_ic2; m_cnt = 0;
  endtask

  // Runs n steps, optionally halting in cycle h (0 = never), checking every cycle.
  task automatic run(input int n, input int h);
    bit step_exp = 1'b0;
    n_steps = 16'(n); start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 3 * n + 1; c++) begin
      int ph;
      bit halted, last;
      ph     = (c - 1) % 3;
      halted = (h != 0) && (c == h + 1);
      last   = (c == 3 * n + 1);
      check("step_done", step_done, step_exp);
      check("v1", $signed(v1), m_v1);
      check("v2", $signed(v2), m_v2);
      check("step_cnt", step_cnt, m_cnt);
      if (halted || last) begin
        check("busy_end", busy, 0);
        check("done_end", done, !halted);
        check("mul_a_end", mul_a, 0);
        break;
      end
      check("busy", busy, 1);
      check("done", done, 0);
      check("mul_a", $signed(mul_a), ph == 0 ? m_v1 : ph == 1 ? m_v2 : 0);
      check("mul_b", $signed(mul_b), ph == 0 ? m_k : ph == 1 ? m_d : 0);
      halt = (c == h);
      if (noise) begin
        cfg_we = 1'b1; cfg_addr = 2'($urandom); cfg_data = W'($urandom);
        load = 1'b1; start = 1'b1;
      end
      tick();
      halt = 1'b0;
      step_exp = (ph == 2) && (c != h);
      if (step_exp) model_step();
    end
    cfg_we = 1'b0; load = 1'b0; start = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] k, d, ic1, ic2;
    int           n;
    logic [W-1:0] e1, e2;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{k: 'h0080000, d: 'h0040000, ic1: 'h0,       ic2: 'h0A00000, n: 1, e1: 'h0005000, e2: 'h09FEC00};
    tbl[1] = '{k: 'h0,       d: 'h0,       ic1: 'h0,       ic2: 'h0A00000, n: 4, e1: 'h0014000, e2: 'h0A00000};
    tbl[2] = '{k: 'h0,       d: 'h0,       ic1: 'h3FFFFFF, ic2: 'h3FFFFFF, n: 1, e1: 'h401FFFE, e2: 'h3FFFFFF};
    tbl[3] = '{k: 'h0,       d: 'h0,       ic1: 'h0,       ic2: 'h7FFFFFF, n: 2, e1: 'h7FFFFFE, e2: 'h7FFFFFF};
    tbl[4] = '{k: 'h0100000, d: 'h0,       ic1: 'h0100000, ic2: 'h0,       n: 1, e1: 'h0100000, e2: 'h7FFF800};

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    load = 1'b0; start = 1'b0; n_steps = '0; halt = 1'b0;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    check_reset_state();

    // Post-reset single step and the 3-step timing pattern.
    run(1, 0);
    check("first_v1", $signed(v1), 'h0005000);
    check("first_v2", $signed(v2), 'h09FEC00);
    check("first_cnt", step_cnt, 1);
    run(3, 0);

    // Config and load, then a run with writes/loads/starts hammered while busy.
    do_cfg(2'd0, 'h0100000);
    do_cfg(2'd2, 'h0100000);
    do_load();
    check("load_v1", $signed(v1), 'h0100000);
    check("load_cnt", step_cnt, 0);
    noise = 1'b1;
    run(4, 0);
    noise = 1'b0;
    run(2, 0);

    // Halt during MUL_D of step 2.
    do_load();
    run(5, 5);
    check("halt_cnt", step_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_idle_busy", busy, 0);
      check("halt_idle_done", done, 0);
    end

    for (int i = 0; i < 5; i++) begin
      do_cfg(2'd0, tbl[i].k);
      do_cfg(2'd1, tbl[i].d);
      do_cfg(2'd2, tbl[i].ic1);
      do_cfg(2'd3, tbl[i].ic2);
      do_load();
      run(tbl[i].n, 0);
      check("tbl_v1", $signed(v1), $signed(tbl[i].e1));
      check("tbl_v2", $signed(v2), $signed(tbl[i].e2));
    end

    for (int i = 0; i < 8; i++) begin
      do_cfg(2'd0, W'($urandom_range(0, 'h200000)));
      do_cfg(2'd1, W'($urandom_range(0, 'h100000)));
      do_cfg(2'd2, W'($urandom));
      do_cfg(2'd3, W'($urandom));
      if (i % 2 == 0) do_load();
      noise = (i % 3 == 1);
      run($urandom_range(1, 8), 0);
      noise = 1'b0;
    end

    // start with n_steps=0 is ignored.
    n_steps = '0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("zero_busy", busy, 0);
      check("zero_done", done, 0);
      tick();
    end

    // load and start together: load wins.
    run(1, 0);
    load = 1'b1; start = 1'b1; n_steps = 16'd3;
    tick();
    load = 1'b0; start = 1'b0;
    m_v1 = m_ic1; m_v2 = m_ic2; m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      check("ls_busy", busy, 0);
      check("ls_v1", $signed(v1), m_v1);
      check("ls_cnt", step_cnt, 0);
      tick();
    end

    // Reset mid-run restores every register.
    n_steps = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_reset_state();
    run(1, 0);
    check("postrst_v2", $signed(v2), 'h09FEC00);

    // Step counter wrap on the CNT_W=4 build.
    do_load();
    run(15, 0);
    run(2, 0);
    check("cnt4_wrap", step_cnt4, 1);
    check("cnt16", step_cnt, 17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dda_step_sequencer.md
Name: dda_step_sequencer

Overview:
Controller for the damped spring-mass DDA solver (dv1/dt = v2, dv2/dt = -(k/m)·v1 - (d/m)·v2). It owns the state registers v1/v2, holds the coefficients and initial conditions, and runs N forward-Euler steps on demand. A single external 7.20 signed multiplier (`signed_mult`) is shared for both products, one product per cycle. It replaces the free-running two-multiplier integrator pair with a start/stop-able, configurable engine for the top-level wrapper.

Parameters:
WIDTH, 27, datapath width, signed 7.20 fixed point
FRAC, 20, fractional bits; informational, must match the external multiplier
DT_SHIFT, 9, Euler time step as an arithmetic right shift (dt = 2^-DT_SHIFT)
CNT_W, 16, width of the step counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_we  in  1  config write strobe
cfg_addr  in  2  0=k_m, 1=d_m, 2=ic1, 3=ic2
cfg_data  in  WIDTH  config write data, signed 7.20
load  in  1  pulse: v1<=ic1, v2<=ic2, step_cnt<=0
start  in  1  pulse: run n_steps Euler steps
n_steps  in  CNT_W  step count, sampled with start
halt  in  1  abort the run
mul_a  out  WIDTH  shared multiplier operand A
mul_b  out  WIDTH  shared multiplier operand B
mul_p  in  WIDTH  multiplier result; combinational, same cycle
v1  out  WIDTH  state: position
v2  out  WIDTH  state: velocity
busy  out  1  run in progress
step_done  out  1  one-cycle pulse per committed step
done  out  1  one-cycle pulse when a run ends normally
step_cnt  out  CNT_W  steps committed since the last load; wraps

Behaviour:
- Reset values:
  - k_m=0x0080000 (0.5), d_m=0x0040000 (0.25), ic1=0, ic2=0x0A00000 (10.0).
  - v1=0, v2=0x0A00000; busy, step_done, done, step_cnt, mul_a, mul_b all 0.
  - FSM=IDLE.
  - rst mid-run aborts immediately and has priority over every other input.
- FSM states: IDLE, MUL_K, MUL_D, UPDATE.
- IDLE:
  - cfg_we writes the selected register.
  - load (checked before start) sets v1<=ic1, v2<=ic2, step_cnt<=0 and stays in IDLE.
  - start with n_steps!=0 latches steps_left=n_steps and goes to MUL_K.
  - start with n_steps=0 is ignored: no busy, no done.
  - load and start in the same cycle: load wins, start is dropped.
- MUL_K: mul_a=v1, mul_b=k_m; register p_k<=mul_p.
- MUL_D: mul_a=v2, mul_b=d_m; register p_d<=mul_p.
- UPDATE:
  - v1<=v1+(v2>>>DT_SHIFT); v2<=v2+((-p_k-p_d)>>>DT_SHIFT). Both use the old v1/v2.
  - All sums are WIDTH-bit two's complement and wrap with no saturation; the shift is arithmetic.
  - step_done pulses next cycle, step_cnt increments and wraps, steps_left decrements.
  - If steps_left was 1: go to IDLE and pulse done next cycle. Otherwise go to MUL_K.
- mul_a and mul_b are 0 in IDLE and UPDATE.
- busy is 1 in MUL_K, MUL_D and UPDATE.
- Timing: start sampled at edge 0 gives MUL_K in cycle 1. For N steps, done and the final v1/v2 appear at cycle 3N+1. Throughput is 3 cycles per step.
- Inputs ignored while busy: cfg_we, load, start.
- halt while busy: next state is IDLE, the current partial step is discarded, v1/v2 keep their last committed values, done is not pulsed. halt in IDLE has no effect.

Test Plan:
- Post-reset single step: start, n_steps=1, with a bit-exact model of `signed_mult` on mul_p. Required: done at cycle 4, v1=0x0005000, v2=0x09FEC00, step_cnt=1, step_done asserted exactly once.
- Timing: n_steps=3. Required: busy high in cycles 1-9, step_done at cycles 4, 7 and 10, done at cycle 10, and mul_a/mul_b showing (v1,k_m) then (v2,d_m) in the correct cycles.
- Config and load: write k_m=0x0100000 and ic1=0x0100000 in IDLE, then load. Required: v1=0x0100000, step_cnt=0. cfg_we during busy must leave the registers unchanged (check after the run).
- Halt: n_steps=5, halt in cycle 5 (second step, MUL_D). Required: IDLE next cycle, v1/v2 equal to the values after step 1, step_cnt=1, no done pulse.
- Wrap: set ic2=0x3FFFFFF and k_m=d_m=0, load, run 1 step. Required: v1 wraps per two's complement. Force step_cnt from 0xFFFF to 0x0000 by running 65536 steps, or with a reduced CNT_W=4 build.
- Edge inputs: start with n_steps=0 gives no busy and no done. load+start in the same cycle gives load only. rst asserted mid-run gives reset values next cycle.
